ram_dma: RTL and testbench

Block-transfer initiator for the single-port `ram` macro. It drives the RAM's `en`/`wr`/`addr`/`data_in` pins and samples its `data_out`, so the RAM is the only responder it talks to. Two modes: copy `len` words from `src` to `dst`, or fill `len` words at `dst` with a constant. It sits between the control logic and one RAM instance and owns that RAM's port while busy.

---
 rtl/ram_dma.sv | 123 ++++++++++++
 tb/tb_ram_dma.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dma.sv
// ============================================================================
// Module   : ram_dma
// Purpose  : Block copy / fill initiator that owns one single-port RAM port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_dma #(
    parameter int DATA_BITS = 8,
    parameter int SIZE      = 256,
    parameter int ADDR_BITS = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDR_BITS-1:0] src,
    input  logic [ADDR_BITS-1:0] dst,
    input  logic [ADDR_BITS:0]   len,
    input  logic [DATA_BITS-1:0] fill_value,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_en,
    output logic                 ram_wr,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0] ram_wdata,
    input  logic [DATA_BITS-1:0] ram_rdata
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;

    localparam logic [ADDR_BITS:0] c_IDX_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic                 r_mode;
    logic [ADDR_BITS-1:0] r_src;
    logic [ADDR_BITS-1:0] r_dst;
    logic [ADDR_BITS:0]   r_len;
    logic [DATA_BITS-1:0] r_fill;
    logic [ADDR_BITS:0]   r_idx;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_done;

    logic [ADDR_BITS:0]   w_idx_next;

    assign w_idx_next = r_idx + c_IDX_ONE;

    // All RAM-side outputs decode from registers only.
    assign busy      = (r_state != c_IDLE);
    assign ram_en    = busy;
    assign ram_wr    = (r_state == c_WRITE);
    assign ram_wdata = (ram_wr && r_mode) ? r_fill : r_data;
    assign done      = r_done;

    always_comb begin
        ram_addr = '0;
        case (r_state)
            c_READ:  ram_addr = r_src + r_idx[ADDR_BITS-1:0];
            c_WRITE: ram_addr = r_dst + r_idx[ADDR_BITS-1:0];
            default: ram_addr = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_mode  <= 1'b0;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_fill  <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // abort wins over a simultaneous start
                    if (start && !abort) begin
                        r_mode <= mode;
                        r_src  <= src;
                        r_dst  <= dst;
                        r_len  <= len;
                        r_fill <= fill_value;
                        r_idx  <= '0;
                        if (len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= mode ? c_WRITE : c_READ;
                        end
                    end
                end
                c_READ: begin
                    if (abort) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_data  <= ram_rdata;
                        r_state <= c_WRITE;
                    end
                end
                c_WRITE: begin
                    if (abort) begin
                        r_state <= c_IDLE;
                    end else if (w_idx_next == r_len) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= w_idx_next;
                        r_state <= r_mode ? c_WRITE : c_READ;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_dma.sv
// ============================================================================
// Module   : tb_ram_dma
// Purpose  : Self-checking bench for ram_dma with an attached RAM and a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_dma;

    logic       clk = 1'b0;
    logic       rst, start, mode, abort;
    logic [7:0] src, dst, fill_value;
    logic [8:0] len;
    logic       busy, done, ram_en, ram_wr;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;

    logic [7:0] mem [256];
    logic       pl_en;
    logic [7:0] pl_addr, pl_data;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
    } op_t;

    op_t        q[$];
    logic [7:0] ref_mem [256];
    logic       m_mode;
    logic [7:0] m_fill, m_last;
    logic       exp_done;
    bit         chk_en;
    int         n_pass, n_tot;

    ram_dma #(.DATA_BITS(8), .SIZE(256)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
        .len(len), .fill_value(fill_value), .abort(abort), .busy(busy),
        .done(done), .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Attached RAM: combinational read, write on posedge; preload port for the bench.
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_en && ram_wr) mem[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Compare DUT outputs with the model, then advance the model by one cycle
    // using the inputs that the next posedge will sample.
    task automatic model_step();
        logic [7:0] wd, sa, da;
        op_t        op;
        wd = m_mode ? m_fill : m_last;
        if (chk_en) begin
            chk("busy", busy, 32'(q.size() != 0));
            chk("done", done, 32'(exp_done));
            chk("ram_en", ram_en, 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("ram_wr", ram_wr, 32'(q[0].wr));
                chk("ram_addr", ram_addr, 32'(q[0].addr));
                if (q[0].wr) chk("ram_wdata", ram_wdata, 32'(wd));
            end else begin
                chk("ram_wr_idle", ram_wr, 32'd0);
            end
        end
        if (pl_en) ref_mem[pl_addr] = pl_data;
        if (rst) begin
            if (q.size() != 0 && q[0].wr) ref_mem[q[0].addr] = wd;
            q.delete();
            exp_done = 1'b0;
        end else if (q.size() != 0) begin
            op = q.pop_front();
            if (op.wr) ref_mem[op.addr] = wd;
            else m_last = ref_mem[op.addr];
            if (abort) begin
                q.delete();
                exp_done = 1'b0;
            end else begin
                exp_done = (q.size() == 0);
            end
        end else begin
            exp_done = 1'b0;
            if (start && !abort) begin
                m_mode = mode;
                m_fill = fill_value;
                if (len == 0) exp_done = 1'b1;
                for (int k = 0; k < int'(len); k++) begin
                    sa = src + 8'(k);
                    da = dst + 8'(k);
                    if (!mode) q.push_back('{wr: 1'b0, addr: sa});
                    q.push_back('{wr: 1'b1, addr: da});
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_args(input logic m, input logic [7:0] s, input logic [7:0] d,
                            input logic [8:0] l, input logic [7:0] f);
        mode = m; src = s; dst = d; len = l; fill_value = f;
    endtask

    task automatic start_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                              input logic [8:0] l, input logic [7:0] f);
        set_args(m, s, d, l, f);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] v);
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        tick();
        pl_en = 1'b0;
    endtask

    // Observe cycles after start until done; optionally re-pulse start mid-transfer.
    task automatic wait_done(output int nbusy, output int ncyc, output int nen,
                             input int inj_cyc);
        bit got;
        nbusy = 0; ncyc = 0; nen = 0; got = 0;
        for (int c = 0; c < 1500; c++) begin
            ncyc++;
            if (done) begin got = 1; break; end
            if (busy) nbusy++;
            if (ram_en) nen++;
            if (ncyc == inj_cyc) begin
                set_args(1'b0, 8'h00, 8'h90, 9'd5, 8'h00);
                start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int nb, nc, ne;

    initial begin
        n_pass = 0; n_tot = 0; chk_en = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; pl_en = 1'b0;
        pl_addr = '0; pl_data = '0;
        set_args(1'b0, 8'h00, 8'h00, 9'd0, 8'h00);
        q.delete(); exp_done = 1'b0; m_mode = 1'b0; m_fill = '0; m_last = '0;
        @(posedge clk); #1;
        tick();
        chk_en = 1;
        for (int a = 0; a < 256; a++) preload(8'(a), 8'($urandom));
        rst = 1'b0;
        tick();

        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_ram_en", ram_en, 32'd0);
        chk("rst_ram_wr", ram_wr, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);

        // Basic copy
        preload(8'h10, 8'hA1); preload(8'h11, 8'hB2);
        preload(8'h12, 8'hC3); preload(8'h13, 8'hD4);
        start_xfer(1'b0, 8'h10, 8'h80, 9'd4, 8'h00);
        wait_done(nb, nc, ne, -1);
        chk("copy_busy_cycles", nb, 32'd8);
        chk("copy_done_cycle", nc, 32'd9);
        chk("copy_dst0", mem[8'h80], 32'hA1);
        chk("copy_dst1", mem[8'h81], 32'hB2);
        chk("copy_dst2", mem[8'h82], 32'hC3);
        chk("copy_dst3", mem[8'h83], 32'hD4);
        chk("copy_src0", mem[8'h10], 32'hA1);
        chk("copy_src3", mem[8'h13], 32'hD4);

        // Fill wrapping past the top address
        preload(8'h02, 8'h33);
        start_xfer(1'b1, 8'h00, 8'hFE, 9'd4, 8'h5A);
        wait_done(nb, nc, ne, -1);
        chk("fill_busy_cycles", nb, 32'd4);
        chk("fill_fe", mem[8'hFE], 32'h5A);
        chk("fill_ff", mem[8'hFF], 32'h5A);
        chk("fill_00", mem[8'h00], 32'h5A);
        chk("fill_01", mem[8'h01], 32'h5A);
        chk("fill_02_untouched", mem[8'h02], 32'h33);

        // Zero length
        start_xfer(1'b0, 8'h10, 8'h80, 9'd0, 8'h00);
        wait_done(nb, nc, ne, -1);
        chk("zero_done_cycle", nc, 32'd1);
        chk("zero_busy", nb, 32'd0);
        chk("zero_ram_en", ne, 32'd0);

        // Start while busy is ignored
        preload(8'h68, 8'h11); preload(8'h90, 8'h22);
        start_xfer(1'b1, 8'h00, 8'h60, 9'd8, 8'h77);
        wait_done(nb, nc, ne, 3);
        chk("swb_busy_cycles", nb, 32'd8);
        for (int k = 0; k < 8; k++) chk("swb_dst", mem[8'h60 + 8'(k)], 32'h77);
        chk("swb_after_range", mem[8'h68], 32'h11);
        chk("swb_new_dst", mem[8'h90], 32'h22);

        // Overlapping copy replicates the first word
        for (int k = 0; k < 4; k++) preload(8'h20 + 8'(k), 8'(k + 1));
        start_xfer(1'b0, 8'h20, 8'h21, 9'd3, 8'h00);
        wait_done(nb, nc, ne, -1);
        for (int k = 0; k < 4; k++) chk("overlap", mem[8'h20 + 8'(k)], 32'd1);

        // Abort during the third write
        for (int k = 0; k < 8; k++) begin
            preload(8'h30 + 8'(k), 8'h30 + 8'(k));
            preload(8'h40 + 8'(k), 8'hEE);
        end
        start_xfer(1'b0, 8'h30, 8'h40, 9'd8, 8'h00);
        repeat (5) tick();
        chk("abort_in_write", ram_wr, 32'd1);
        chk("abort_wr_addr", ram_addr, 32'h42);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 32'd0);
        chk("abort_done", done, 32'd0);
        tick();
        chk("abort_done_late", done, 32'd0);
        chk("abort_w0", mem[8'h40], 32'h30);
        chk("abort_w1", mem[8'h41], 32'h31);
        chk("abort_w2", mem[8'h42], 32'h32);
        chk("abort_w3", mem[8'h43], 32'hEE);
        start_xfer(1'b1, 8'h00, 8'hF0, 9'd1, 8'h9C);
        wait_done(nb, nc, ne, -1);
        chk("after_abort_fill", mem[8'hF0], 32'h9C);

        // Reset during a read
        start_xfer(1'b0, 8'h10, 8'hA0, 9'd4, 8'h00);
        tick(); tick();
        chk("rst_mid_in_read", ram_wr, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstm_busy", busy, 32'd0);
        chk("rstm_done", done, 32'd0);
        chk("rstm_ram_en", ram_en, 32'd0);
        chk("rstm_ram_wr", ram_wr, 32'd0);
        chk("rstm_ram_addr", ram_addr, 32'd0);
        chk("rstm_ram_wdata", ram_wdata, 32'd0);
        tick();
        chk("rstm_done_late", done, 32'd0);
        start_xfer(1'b0, 8'h10, 8'hA0, 9'd4, 8'h00);
        wait_done(nb, nc, ne, -1);
        chk("rstm_copy_cycles", nc, 32'd9);
        chk("rstm_copy_a3", mem[8'hA3], 32'hD4);

        // Randomised traffic with sporadic abort, reset and stray starts
        for (int t = 0; t < 30; t++) begin
            start_xfer(1'(($urandom % 2)), 8'($urandom), 8'($urandom),
                       (($urandom % 10) == 0) ? 9'd256 : 9'($urandom_range(0, 12)),
                       8'($urandom));
            for (int c = 0; c < 1200; c++) begin
                if (!busy) break;
                abort = (($urandom % 30) == 0);
                rst   = (($urandom % 90) == 0);
                if (($urandom % 8) == 0) begin
                    set_args(1'(($urandom % 2)), 8'($urandom), 8'($urandom),
                             9'($urandom_range(0, 12)), 8'($urandom));
                    start = 1'b1;
                end
                tick();
                abort = 1'b0; rst = 1'b0; start = 1'b0;
            end
        end
        tick(); tick();

        for (int a = 0; a < 256; a++) chk("final_mem", mem[a], 32'(ref_mem[a]));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire
